// File: rtl/dpll_pkg.sv
// Shared types and defaults for the increment/decrement DPLL clock divider.
package dpll_pkg;

  localparam int DPLL_DIV_N_DEFAULT  = 8;
  localparam int DPLL_PEND_W_DEFAULT = 2;

  // Which period length is running: nominal, one cycle short, one cycle long.
  typedef enum logic [1:0] {
    NOM   = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } period_e;

endpackage

// File: rtl/dpll_pend_cnt.sv
// Saturating pending-request counter for one side (advance or retard) of the DPLL.
module dpll_pend_cnt
  import dpll_pkg::*;
#(
  parameter int PEND_W = DPLL_PEND_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,        // own-side request, already free of add+sub collisions
  input  logic              opp_req,    // opposite-side request, may cancel one of ours
  input  logic              opp_absorb, // opposite counter cancelled our request instead
  input  logic              consume,    // wrap is using one pending request this cycle
  output logic [PEND_W-1:0] count,
  output logic              inc,
  output logic              dec,
  output logic              inc_drop
);

  localparam logic [PEND_W-1:0] MAX = '1;

  logic [PEND_W-1:0] avail;

  // Requests and cancellations act on what is left after the wrap consumption.
  always_comb begin
    avail    = count - PEND_W'(consume);
    inc      = req && !opp_absorb && (avail != MAX);
    inc_drop = req && !opp_absorb && (avail == MAX);
    dec      = opp_req && (avail != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= avail + PEND_W'(inc) - PEND_W'(dec);
  end

endmodule

// File: rtl/dpll_idc.sv
// Increment/decrement DPLL divider: recovered clock whose low phase shrinks or grows by one cycle.
// Optional sticky overflow flag enabled by defining DPLL_IDC_OVF_EN.
module dpll_idc
  import dpll_pkg::*;
#(
  parameter int DIV_N  = DPLL_DIV_N_DEFAULT,
  parameter int PEND_W = DPLL_PEND_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic add,
  input  logic sub,
  output logic idout,
  output logic wrap,
  output logic adj_ovf
);

  localparam int CNT_W = $clog2(DIV_N + 1);
  localparam int HALF  = DIV_N / 2;

  period_e           state, state_next;
  logic [CNT_W-1:0]  cnt, last;
  logic [PEND_W-1:0] add_pend, sub_pend;
  logic              add_v, sub_v;
  logic              add_consume, sub_consume;
  logic              add_inc, add_dec, add_drop;
  logic              sub_inc, sub_dec, sub_drop;
  logic              unused_inc;

  // Simultaneous add and sub cancel each other outright.
  assign add_v = add & ~sub;
  assign sub_v = sub & ~add;

  always_comb begin
    last = CNT_W'(DIV_N - 1);
    case (state)
      SHORT:   last = CNT_W'(DIV_N - 2);
      LONG:    last = CNT_W'(DIV_N);
      default: last = CNT_W'(DIV_N - 1);
    endcase
  end

  assign wrap        = (cnt == last);
  assign add_consume = wrap && (add_pend != '0);
  assign sub_consume = wrap && (add_pend == '0) && (sub_pend != '0);

  always_comb begin
    state_next = state;
    if (wrap) begin
      if (add_consume)      state_next = SHORT;
      else if (sub_consume) state_next = LONG;
      else                  state_next = NOM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NOM;
      cnt   <= '0;
      idout <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= wrap ? '0 : cnt + CNT_W'(1);
      idout <= (cnt < CNT_W'(HALF));
    end
  end

  dpll_pend_cnt #(.PEND_W(PEND_W)) u_add (
    .clk        (clk),
    .rst        (rst),
    .req        (add_v),
    .opp_req    (sub_v),
    .opp_absorb (sub_dec),
    .consume    (add_consume),
    .count      (add_pend),
    .inc        (add_inc),
    .dec        (add_dec),
    .inc_drop   (add_drop)
  );

  dpll_pend_cnt #(.PEND_W(PEND_W)) u_sub (
    .clk        (clk),
    .rst        (rst),
    .req        (sub_v),
    .opp_req    (add_v),
    .opp_absorb (add_dec),
    .consume    (sub_consume),
    .count      (sub_pend),
    .inc        (sub_inc),
    .dec        (sub_dec),
    .inc_drop   (sub_drop)
  );

  assign unused_inc = add_inc ^ sub_inc;

`ifdef DPLL_IDC_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   adj_ovf <= 1'b0;
    else if (add_drop || sub_drop) adj_ovf <= 1'b1;
  end
`else
  logic unused_drop;
  assign unused_drop = add_drop | sub_drop;
  assign adj_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_dpll_idc.sv
// Self-checking bench for dpll_idc: signed net-pending period model plus directed period-length checks.
module tb_dpll_idc;

  localparam int DIV_N  = 8;
  localparam int PEND_W = 2;
  localparam int MAXP   = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic add = 1'b0;
  logic sub = 1'b0;
  logic idout, wrap, adj_ovf;

  int passed = 0;
  int total  = 0;

  dpll_idc #(.DIV_N(DIV_N), .PEND_W(PEND_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .add     (add),
    .sub     (sub),
    .idout   (idout),
    .wrap    (wrap),
    .adj_ovf (adj_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: position in period, period length, and net pending (+ advance, - retard).
  int pos = 0;
  int len = DIV_N;
  int p   = 0;
  bit idq = 1'b0;
  bit ovf_m = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos = 0; len = DIV_N; p = 0; idq = 1'b0; ovf_m = 1'b0;
    end else begin : step
      int r;
      bit w;
      w   = (pos == len - 1);
      idq = (pos < DIV_N / 2);
      r   = (add && !sub) ? 1 : ((sub && !add) ? -1 : 0);
      if (w) begin
        pos = 0;
        if (p > 0)      begin len = DIV_N - 1; p--; end
        else if (p < 0) begin len = DIV_N + 1; p++; end
        else            len = DIV_N;
      end else begin
        pos++;
      end
      if (r == 1) begin
        if (p < 0) p++;
        else if (p == MAXP) ovf_m = 1'b1;
        else p++;
      end else if (r == -1) begin
        if (p > 0) p--;
        else if (p == -MAXP) ovf_m = 1'b1;
        else p--;
      end
    end
  end

  // Observed period lengths and high-phase widths, delimited by wrap.
  int plen[$];
  int phi[$];
  int cur_len = 0;
  int cur_hi  = 0;

  always @(negedge clk) begin
    bit exp_ovf;
`ifdef DPLL_IDC_OVF_EN
    exp_ovf = ovf_m;
`else
    exp_ovf = 1'b0;
`endif
    check("wrap", int'(wrap), int'(!rst && (pos == len - 1)));
    check("idout", int'(idout), int'(idq));
    check("adj_ovf", int'(adj_ovf), int'(exp_ovf));
    if (rst) begin
      cur_len = 0; cur_hi = 0;
    end else begin
      cur_len++;
      if (idout) cur_hi++;
      if (wrap) begin
        plen.push_back(cur_len);
        phi.push_back(cur_hi);
        cur_len = 0; cur_hi = 0;
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_periods(input int n);
    int target;
    target = plen.size() + n;
    for (int i = 0; i < 200 && plen.size() < target; i++) begin
      @(posedge clk); #2;
    end
    check("period_timeout", int'(plen.size() >= target), 1);
  endtask

  task automatic expect_periods(input string tag, input int q0, input int exp_len[6], input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_len%0d", tag, i), (q0 + i < plen.size()) ? plen[q0 + i] : -1, exp_len[i]);
  endtask

  initial begin
    int q0;
    int exp_ovf_lit;
`ifdef DPLL_IDC_OVF_EN
    exp_ovf_lit = 1;
`else
    exp_ovf_lit = 0;
`endif

    // Reset state, then free-running 8-cycle periods.
    cycles(3);
    check("rst_idout", int'(idout), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_ovf", int'(adj_ovf), 0);
    rst = 1'b0;
    q0 = plen.size();
    wait_periods(2);
    expect_periods("free", q0, '{8, 8, 0, 0, 0, 0}, 2);
    check("free_hi0", phi[q0], 4);

    // Single add: 8 (current), 7 (4 high / 3 low), 8.
    cycles(2);
    q0 = plen.size();
    add = 1'b1; cycles(1); add = 1'b0;
    wait_periods(3);
    expect_periods("add1", q0, '{8, 7, 8, 0, 0, 0}, 3);
    check("add1_hi", phi[q0 + 1], 4);

    // Single sub: 8, 9 (4 high / 5 low), 8.
    wait_periods(1);
    cycles(2);
    q0 = plen.size();
    sub = 1'b1; cycles(1); sub = 1'b0;
    wait_periods(3);
    expect_periods("sub1", q0, '{8, 9, 8, 0, 0, 0}, 3);
    check("sub1_hi", phi[q0 + 1], 4);

    // add and sub together: ignored.
    wait_periods(1);
    cycles(2);
    q0 = plen.size();
    add = 1'b1; sub = 1'b1; cycles(1); add = 1'b0; sub = 1'b0;
    check("both_add_pend", int'(dut.add_pend), 0);
    check("both_sub_pend", int'(dut.sub_pend), 0);
    wait_periods(2);
    expect_periods("both", q0, '{8, 8, 0, 0, 0, 0}, 2);

    // add then sub within one period: cancel.
    wait_periods(1);
    q0 = plen.size();
    cycles(1);
    add = 1'b1; cycles(1); add = 1'b0;
    cycles(1);
    sub = 1'b1; cycles(1); sub = 1'b0;
    check("cancel_add_pend", int'(dut.add_pend), 0);
    check("cancel_sub_pend", int'(dut.sub_pend), 0);
    wait_periods(3);
    expect_periods("cancel", q0, '{8, 8, 8, 0, 0, 0}, 3);

    // Five adds in one period: saturate at 3, then 7,7,7,8.
    wait_periods(1);
    q0 = plen.size();
    add = 1'b1; cycles(5); add = 1'b0;
    check("sat_ovf", int'(adj_ovf), exp_ovf_lit);
    wait_periods(5);
    expect_periods("sat", q0, '{8, 7, 7, 7, 8, 0}, 5);

    // Three adds, then reset at cnt=5 for two cycles.
    wait_periods(1);
    add = 1'b1; cycles(3); add = 1'b0;
    cycles(2);
    rst = 1'b1;
    #1;
    check("midrst_idout", int'(idout), 0);
    check("midrst_wrap", int'(wrap), 0);
    check("midrst_ovf", int'(adj_ovf), 0);
    cycles(2);
    rst = 1'b0;
    q0 = plen.size();
    wait_periods(3);
    expect_periods("postrst", q0, '{8, 8, 8, 0, 0, 0}, 3);

    // Saturated counter with an add on the consuming wrap cycle is not dropped.
    wait_periods(1);
    add = 1'b1; cycles(3); add = 1'b0;
    for (int i = 0; i < 20 && !wrap; i++) cycles(1);
    q0 = plen.size();
    add = 1'b1; cycles(1); add = 1'b0;
    wait_periods(6);
    expect_periods("wrapadd", q0, '{8, 7, 7, 7, 7, 8}, 6);
    check("wrapadd_ovf", int'(adj_ovf), 0);

    cycles(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dpll_idc.md
DPLL_IDC -- requirements
Module: dpll_idc

Interface
REQ-001 Parameter DIV_N, default 8, nominal output period in clk cycles; even, >= 4.
REQ-002 Parameter PEND_W, default 2, width of each pending-request counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 add  input  1  one-cycle advance request from the loop filter.
REQ-006 sub  input  1  one-cycle retard request from the loop filter.
REQ-007 idout  output  1  recovered clock, registered.
REQ-008 wrap  output  1  one-cycle pulse on the last clk cycle of each idout period.
REQ-009 adj_ovf  output  1  sticky flag: a request was dropped at saturation.

Function
REQ-010 Period counter cnt SHALL run 0..L-1, then return to 0; L is fixed for the whole period.
REQ-011 Period state machine SHALL have states NOM (L=DIV_N), SHORT (L=DIV_N-1) and LONG (L=DIV_N+1).
REQ-012 idout SHALL be 1 for cnt 0..DIV_N/2-1 and 0 for all remaining counts, with 1-cycle register latency: idout(t+1) = (cnt(t) < DIV_N/2).
- SHORT and LONG therefore change only the low phase.
REQ-013 wrap SHALL be high combinationally when cnt == L-1.
REQ-014 At wrap the next state SHALL be chosen as follows:
- add_pend > 0: SHORT, and add_pend decrements.
- else sub_pend > 0: LONG, and sub_pend decrements.
- else NOM.
REQ-015 If add and sub are both high in the same cycle, both SHALL be ignored.
REQ-016 Cancellation rules:
- add while sub_pend > 0 SHALL decrement sub_pend instead of incrementing add_pend.
- sub while add_pend > 0 SHALL decrement add_pend, symmetrically.
REQ-017 Simultaneous request and wrap-consumption SHALL net in the same cycle: pend_next = pend + req - consumed.
- The wrap decision uses the pre-update pend.
REQ-018 A request arriving when its pending counter equals 2^PEND_W-1 and is not consumed that cycle SHALL be dropped, and sets adj_ovf.
REQ-019 add and sub SHALL be treated as level-per-cycle; a high held for k cycles SHALL count as k requests.

Reset
REQ-020 While rst=1 the block SHALL hold:
- cnt=0, state=NOM, add_pend=0, sub_pend=0.
- idout=0, adj_ovf=0 (wrap=0 follows from cnt=0).
REQ-021 rst asserted mid-period SHALL abort that period immediately and discard all pending requests.
REQ-022 After rst release, idout SHALL rise on the first clk edge, and the first wrap SHALL occur at cnt=DIV_N-1.

Configuration
REQ-023 Macro DPLL_IDC_OVF_EN defined: adj_ovf SHALL be implemented per REQ-018, sticky until rst.
REQ-024 Macro DPLL_IDC_OVF_EN undefined: adj_ovf SHALL be tied 0; saturation drop behaviour is unchanged.

Structure
REQ-025 Package dpll_pkg SHALL hold:
- the period-state enum (NOM, SHORT, LONG);
- DPLL_DIV_N_DEFAULT = 8;
- DPLL_PEND_W_DEFAULT = 2.
REQ-026 Sub-module dpll_pend_cnt SHALL implement one saturating up/down pending counter with inc, dec, inc_drop outputs.
- It SHALL be instantiated twice (add side, sub side).

Verification
REQ-027 No requests after reset (DIV_N=8):
- idout pattern is 4 high / 4 low, repeating.
- wrap pulses every 8 cycles, first at the 8th cycle after release.
REQ-028 Single add pulse mid-period: the following period is 7 cycles (4 high / 3 low), then 8-cycle periods resume.
REQ-029 Single sub pulse mid-period: the following period is 9 cycles (4 high / 5 low), then 8-cycle periods resume.
REQ-030 Cancellation cases both give the next period 8 cycles and both pending counters 0:
- add and sub in the same cycle;
- add then sub within one period.
REQ-031 Five add pulses within one period, PEND_W=2:
- three consecutive 7-cycle periods, then 8-cycle periods.
- adj_ovf=1 with DPLL_IDC_OVF_EN, 0 without.
REQ-032 Three add pulses, then rst for 2 cycles at cnt=5:
- idout=0 and wrap=0 immediately;
- after release, periods are 8 cycles with no residual SHORT periods.
